mmio_uart_periph: RTL and testbench

Memory-mapped peripheral block for the MIPS core's I/O window. It holds a parametrised GPIO output register (LEDs and anodes), buffered UART transmit and receive through TX/RX FIFOs, a status register with clear-on-read sticky flags, a control register, and an interrupt line. It sits between the CPU data port (peripheral-select path) and the external uart_tx/uart_rx serializers.

---
 rtl/mmio_uart_pkg.sv | 37 +++
 rtl/mmio_uart_sync_fifo.sv | 59 +++++
 rtl/mmio_uart_periph.sv | 181 ++++++++++++++++++
 tb/tb_mmio_uart_periph.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Register map, STATUS/CTRL bit positions and TX sequencer encoding shared by
// the MMIO UART peripheral and its FIFOs.
package mmio_uart_pkg;

  localparam logic [7:0] ADDR_GPIO   = 8'h10;
  localparam logic [7:0] ADDR_TXDATA = 8'h18;
  localparam logic [7:0] ADDR_RXDATA = 8'h1C;
  localparam logic [7:0] ADDR_STATUS = 8'h20;
  localparam logic [7:0] ADDR_CTRL   = 8'h24;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_BUSY      = 3;
  localparam int ST_TX_DONE      = 4;
  localparam int ST_RX_OVF       = 5;
  localparam int ST_TX_OVF       = 6;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;
  localparam int CTRL_RX_IE    = 4;
  localparam int CTRL_TX_IE    = 5;

  localparam int TX_TIMEOUT = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_ACT,
    TX_WAIT_DONE
  } txState_e;

endpackage

// File: rtl/mmio_uart_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset && !flush_i && doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_periph.sv
// MMIO peripheral: GPIO register, buffered UART TX/RX with a TX start
// sequencer, clear-on-read sticky status flags and a registered interrupt.
module mmio_uart_periph
  import mmio_uart_pkg::*;
#(
  parameter int GPIO_W   = 12,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [7:0]        addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              irq
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic wrEn, rdEn, statusRd;
  logic txPush, txPop, txFlush, txFull, txEmpty;
  logic rxPush, rxPop, rxFlush, rxFull, rxEmpty;
  logic [7:0] txHead, rxHead;
  logic [TXCW-1:0] txCount;
  logic [RXCW-1:0] rxCount;
  logic txGo, txDoneSet, txOvfSet, rxOvfSet;
  logic [31:0] statusWord, ctrlWord, rdMux;
  logic unusedWrData;

  txState_e          state_q;
  logic [4:0]        timer_q;
  logic              txDv_q;
  logic [7:0]        txByte_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [31:0]       rdData_q;
  logic              txEn_q, rxEn_q, rxIe_q, txIe_q, irq_q;
  logic              txDoneStk_q, rxOvf_q, txOvf_q;
  logic              txDoneStk_d, rxOvf_d, txOvf_d;

  // A simultaneous read and write behaves as a write only.
  assign wrEn     = sel & mem_write;
  assign rdEn     = sel & mem_read & ~mem_write;
  assign statusRd = rdEn & (addr == ADDR_STATUS);

  assign txGo      = (state_q == TX_IDLE) & txEn_q & ~txEmpty & ~tx_active;
  assign txPop     = txGo;
  assign txPush    = wrEn & (addr == ADDR_TXDATA);
  assign txFlush   = wrEn & (addr == ADDR_CTRL) & wr_data[CTRL_TX_FLUSH];
  assign rxPush    = rx_dv & rxEn_q;
  assign rxPop     = rdEn & (addr == ADDR_RXDATA);
  assign rxFlush   = wrEn & (addr == ADDR_CTRL) & wr_data[CTRL_RX_FLUSH];
  assign txDoneSet = (state_q == TX_WAIT_DONE) & tx_done;
  assign txOvfSet  = txPush & txFull & ~txPop;
  assign rxOvfSet  = rxPush & rxFull & ~rxPop;
  assign unusedWrData = ^wr_data;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
    .clk(clk), .reset(reset), .push_i(txPush), .pop_i(txPop), .flush_i(txFlush),
    .wdata_i(wr_data[7:0]), .rdata_o(txHead), .full_o(txFull), .empty_o(txEmpty),
    .count_o(txCount)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rxFifo (
    .clk(clk), .reset(reset), .push_i(rxPush), .pop_i(rxPop), .flush_i(rxFlush),
    .wdata_i(rx_byte), .rdata_o(rxHead), .full_o(rxFull), .empty_o(rxEmpty),
    .count_o(rxCount)
  );

  always_comb begin
    statusWord = '0;
    statusWord[ST_RX_NONEMPTY] = ~rxEmpty;
    statusWord[ST_TX_FULL]     = txFull;
    statusWord[ST_TX_EMPTY]    = txEmpty;
    statusWord[ST_TX_BUSY]     = (state_q != TX_IDLE) | tx_active;
    statusWord[ST_TX_DONE]     = txDoneStk_q;
    statusWord[ST_RX_OVF]      = rxOvf_q;
    statusWord[ST_TX_OVF]      = txOvf_q;
    statusWord[ST_RX_COUNT_LSB +: 8] = 8'(rxCount);
    statusWord[ST_TX_COUNT_LSB +: 8] = 8'(txCount);

    ctrlWord = '0;
    ctrlWord[CTRL_TX_EN] = txEn_q;
    ctrlWord[CTRL_RX_EN] = rxEn_q;
    ctrlWord[CTRL_RX_IE] = rxIe_q;
    ctrlWord[CTRL_TX_IE] = txIe_q;

    rdMux = '0;
    case (addr)
      ADDR_GPIO:   rdMux = 32'(gpio_q);
      ADDR_RXDATA: rdMux = rxEmpty ? 32'h0 : {24'h0, rxHead};
      ADDR_STATUS: rdMux = statusWord;
      ADDR_CTRL:   rdMux = ctrlWord;
      default:     rdMux = '0;
    endcase

    // A set in the same cycle as the clearing read keeps the flag high.
    txDoneStk_d = txDoneSet | (txDoneStk_q & ~statusRd);
    rxOvf_d     = rxOvfSet  | (rxOvf_q     & ~statusRd);
    txOvf_d     = txOvfSet  | (txOvf_q     & ~statusRd);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_q      <= '0;
      rdData_q    <= '0;
      txEn_q      <= 1'b1;
      rxEn_q      <= 1'b1;
      rxIe_q      <= 1'b0;
      txIe_q      <= 1'b0;
      txDoneStk_q <= 1'b0;
      rxOvf_q     <= 1'b0;
      txOvf_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wrEn && addr == ADDR_GPIO) gpio_q <= wr_data[GPIO_W-1:0];
      if (wrEn && addr == ADDR_CTRL) begin
        txEn_q <= wr_data[CTRL_TX_EN];
        rxEn_q <= wr_data[CTRL_RX_EN];
        rxIe_q <= wr_data[CTRL_RX_IE];
        txIe_q <= wr_data[CTRL_TX_IE];
      end
      if (rdEn) rdData_q <= rdMux;
      txDoneStk_q <= txDoneStk_d;
      rxOvf_q     <= rxOvf_d;
      txOvf_q     <= txOvf_d;
      irq_q       <= (rxIe_q & ~rxEmpty) | (txIe_q & txEmpty & (state_q == TX_IDLE));
    end
  end

  // The head byte is popped on the IDLE->START edge and held in txByte_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= TX_IDLE;
      timer_q  <= '0;
      txDv_q   <= 1'b0;
      txByte_q <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (txGo) begin
            state_q  <= TX_START;
            txDv_q   <= 1'b1;
            txByte_q <= txHead;
          end
        end
        TX_START: begin
          txDv_q  <= 1'b0;
          timer_q <= '0;
          state_q <= TX_WAIT_ACT;
        end
        TX_WAIT_ACT: begin
          if (tx_active) state_q <= TX_WAIT_DONE;
          else if (timer_q == 5'(TX_TIMEOUT - 1)) state_q <= TX_IDLE;
          else timer_q <= timer_q + 1'b1;
        end
        TX_WAIT_DONE: begin
          if (tx_done) state_q <= TX_IDLE;
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign rd_data  = rdData_q;
  assign gpio_out = gpio_q;
  assign tx_dv    = txDv_q;
  assign tx_byte  = txByte_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_uart_periph.sv
// Scoreboard bench for mmio_uart_periph: bus reads and TX bytes are queued as
// expectations and checked by an independent monitor; uart_tx is modelled.
module tb_mmio_uart_periph;

  localparam logic [7:0] A_GPIO   = 8'h10;
  localparam logic [7:0] A_TXDATA = 8'h18;
  localparam logic [7:0] A_RXDATA = 8'h1C;
  localparam logic [7:0] A_STATUS = 8'h20;
  localparam logic [7:0] A_CTRL   = 8'h24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [11:0] gpio_out;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int dvSeen = 0;
  logic rdPipe = 1'b0;
  logic [31:0] expRd[$];
  string       expRdTag[$];
  logic [7:0]  expTx[$];

  always #5 clk = ~clk;

  mmio_uart_periph #(.GPIO_W(12), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .mem_read(mem_read),
    .mem_write(mem_write), .wr_data(wr_data), .rd_data(rd_data), .gpio_out(gpio_out),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .rx_dv(rx_dv), .rx_byte(rx_byte), .irq(irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic doWr, input logic doRd, input logic [7:0] a,
                               input logic [31:0] d, input logic doRx, input logic [7:0] rxB,
                               input logic [31:0] expVal, input string tag);
    sel = doWr | doRd;
    mem_write = doWr;
    mem_read = doRd;
    addr = a;
    wr_data = d;
    rx_dv = doRx;
    rx_byte = rxB;
    if (doRd && !doWr) begin
      expRd.push_back(expVal);
      expRdTag.push_back(tag);
    end
    @(posedge clk);
    #1;
    sel = 1'b0;
    mem_write = 1'b0;
    mem_read = 1'b0;
    addr = '0;
    wr_data = '0;
    rx_dv = 1'b0;
    rx_byte = '0;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 1'b0, 8'h00, 32'h0, "");
  endtask

  task automatic busRead(input logic [7:0] a, input logic [31:0] exp, input string tag);
    applyStimulus(1'b0, 1'b1, a, 32'h0, 1'b0, 8'h00, exp, tag);
  endtask

  task automatic rxPulse(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, b, 32'h0, "");
  endtask

  task automatic waitDone(input int target, input int limit, input string tag);
    int n = 0;
    while (doneCount < target && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput(tag, doneCount, target);
  endtask

  // uart_tx model: busy for 20 cycles after each start pulse, then a done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        @(posedge clk);
        #1 tx_active = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_active = 1'b0;
        tx_done = 1'b1;
        doneCount++;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  always @(posedge clk) rdPipe <= sel & mem_read & ~mem_write & reset;

  // Monitor: pops expected read data and TX bytes when the DUT presents them.
  always @(negedge clk) begin
    if (rdPipe) begin
      if (expRd.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRead: got 0x%08h, expected no read", rd_data);
      end else begin
        checkOutput(expRdTag.pop_front(), rd_data, expRd.pop_front());
      end
    end
    if (tx_dv) begin
      if (expTx.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedTx: got byte 0x%02h, expected no start pulse", tx_byte);
      end else begin
        checkOutput("txByte", {24'h0, tx_byte}, {24'h0, expTx.pop_front()});
      end
      checkOutput("txAfterDone", doneCount, dvSeen);
      dvSeen++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    // Reset state
    tick(2);
    checkOutput("rstGpio", {20'h0, gpio_out}, 32'h0);
    checkOutput("rstRdData", rd_data, 32'h0);
    checkOutput("rstTxDv", {31'h0, tx_dv}, 32'h0);
    checkOutput("rstTxByte", {24'h0, tx_byte}, 32'h0);
    checkOutput("rstIrq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    tick(1);

    // GPIO, CTRL readback, read+write collision, unmapped read
    busWrite(A_GPIO, 32'h0000_0ABC);
    checkOutput("gpioWrite", {20'h0, gpio_out}, 32'h0000_0ABC);
    busRead(A_CTRL, 32'h0000_0003, "ctrlReset");
    applyStimulus(1'b1, 1'b1, A_GPIO, 32'hFFFF_F123, 1'b0, 8'h00, 32'h0, "");
    checkOutput("rwGpio", {20'h0, gpio_out}, 32'h0000_0123);
    checkOutput("rwRdHold", rd_data, 32'h0000_0003);
    busRead(8'h30, 32'h0, "unmappedRead");
    busRead(A_GPIO, 32'h0000_0123, "gpioRead");

    // Three frames in order, then clear-on-read of tx_done_sticky
    expTx.push_back(8'h41);
    expTx.push_back(8'h42);
    expTx.push_back(8'h43);
    busWrite(A_TXDATA, 32'h41);
    busWrite(A_TXDATA, 32'h42);
    busWrite(A_TXDATA, 32'h43);
    waitDone(3, 200, "t2Frames");
    tick(3);
    busRead(A_STATUS, 32'h0000_0014, "t2Status");
    busRead(A_STATUS, 32'h0000_0004, "t2StatusCleared");

    // TX overflow while the sequencer is disabled
    busWrite(A_CTRL, 32'h2);
    for (int i = 0; i < 5; i++) busWrite(A_TXDATA, 32'h51 + i);
    busRead(A_STATUS, 32'h0004_0042, "t3StatusFull");
    for (int i = 0; i < 4; i++) expTx.push_back(8'h51 + 8'(i));
    busWrite(A_CTRL, 32'h3);
    waitDone(7, 400, "t3Frames");
    tick(40);
    checkOutput("t3FrameCount", dvSeen, 7);
    busRead(A_STATUS, 32'h0000_0014, "t3StatusDone");

    // RX overflow and drain, including read of an empty FIFO
    for (int i = 0; i < 5; i++) rxPulse(8'h10 + 8'(i));
    busRead(A_STATUS, 32'h0000_0425, "t4StatusFull");
    for (int i = 0; i < 4; i++) busRead(A_RXDATA, 32'h10 + i, "t4RxData");
    busRead(A_RXDATA, 32'h0, "t4RxEmpty");
    busRead(A_STATUS, 32'h0000_0004, "t4StatusEmpty");

    // Push and pop in the same cycle
    rxPulse(8'h21);
    rxPulse(8'h22);
    applyStimulus(1'b0, 1'b1, A_RXDATA, 32'h0, 1'b1, 8'h23, 32'h21, "t5PopPush");
    busRead(A_STATUS, 32'h0000_0205, "t5Count");
    busRead(A_RXDATA, 32'h22, "t5Rx1");
    busRead(A_RXDATA, 32'h23, "t5Rx2");
    busRead(A_STATUS, 32'h0000_0004, "t5StatusEmpty");

    // Interrupt and reset in the middle of a frame
    busWrite(A_CTRL, 32'h13);
    checkOutput("t6IrqIdle", {31'h0, irq}, 32'h0);
    rxPulse(8'h77);
    tick(1);
    checkOutput("t6IrqSet", {31'h0, irq}, 32'h1);
    busRead(A_RXDATA, 32'h77, "t6RxData");
    tick(1);
    checkOutput("t6IrqClear", {31'h0, irq}, 32'h0);
    expTx.push_back(8'h99);
    busWrite(A_TXDATA, 32'h99);
    busWrite(A_TXDATA, 32'h9A);
    rxPulse(8'h55);
    rxPulse(8'h66);
    n = 0;
    while (!tx_active && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput("t6ActiveSeen", {31'h0, tx_active}, 32'h1);
    tick(3);
    checkOutput("t6IrqPreReset", {31'h0, irq}, 32'h1);
    reset = 1'b0;
    tick(2);
    checkOutput("t6RstTxDv", {31'h0, tx_dv}, 32'h0);
    checkOutput("t6RstIrq", {31'h0, irq}, 32'h0);
    checkOutput("t6RstGpio", {20'h0, gpio_out}, 32'h0);
    checkOutput("t6RstRdData", rd_data, 32'h0);
    reset = 1'b1;
    waitDone(8, 100, "t6FrameDrain");
    tick(3);
    busRead(A_STATUS, 32'h0000_0004, "t6StatusEmpty");
    busRead(A_CTRL, 32'h0000_0003, "t6CtrlReset");
    tick(30);
    checkOutput("t6IrqAfter", {31'h0, irq}, 32'h0);

    tick(3);
    checkOutput("rdQueueDrained", expRd.size(), 32'h0);
    checkOutput("txQueueDrained", expTx.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
